jk_mod_counter: RTL and testbench
=================================

JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 4, which is the counter bit width.
REQ-002 The block SHALL take parameter MOD, default 10, which is the count modulus; it SHALL satisfy 2 <= MOD <= 2**WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin counting.
REQ-006 The block SHALL have port stop, input, 1 bit: request to halt counting.
REQ-007 The block SHALL have port en, input, 1 bit: count enable, valid in RUN only.
REQ-008 The block SHALL have port up, input, 1 bit: direction select, 1 = increment, 0 = decrement.
REQ-009 The block SHALL have port load, input, 1 bit: parallel-load strobe.
REQ-010 The block SHALL have port din, input, WIDTH bits: parallel-load value.
REQ-011 The block SHALL have port q, output, WIDTH bits: registered count.
REQ-012 The block SHALL have port qb, output, WIDTH bits: bitwise complement of q, combinational.
REQ-013 The block SHALL have port tc, output, 1 bit: registered terminal-count (wrap) pulse.
REQ-014 The block SHALL have port busy, output, 1 bit: high while the FSM is in RUN.
REQ-015 The block SHALL have port err, output, 1 bit: sticky flag set by an out-of-range load.

Function
REQ-016 Each bit q[i] SHALL update as q[i] <= (J[i] & ~q[i]) | (~K[i] & q[i]); J/K per bit are derived from toggle, load and wrap conditions (J=K=1 toggle, J=1 K=0 set, J=0 K=1 clear, J=K=0 hold).
REQ-017 The FSM SHALL have states IDLE and RUN, encoded in a state register.
- IDLE -> RUN when start=1 and stop=0.
- RUN -> IDLE when stop=1.
- start=stop=1 in the same cycle: stop wins, and the FSM goes to or stays in IDLE.
REQ-018 Per-cycle priority SHALL be rst > load > count; load does not change FSM state, and load in the same cycle as stop performs both.
REQ-019 Load with din <= MOD-1 SHALL set q <= din on the next edge.
REQ-020 Load with din >= MOD SHALL set q <= MOD-1 and err <= 1.
REQ-021 In RUN with en=1, load=0 and stop=0, q SHALL advance by 1 per edge: up=1 gives q+1, up=0 gives q-1.
REQ-022 Counting SHALL wrap modulo MOD:
- up=1 at q=MOD-1 gives q <= 0.
- up=0 at q=0 gives q <= MOD-1.
REQ-023 tc SHALL be 1 for exactly the one cycle in which q holds a just-wrapped value, and 0 otherwise; a load never asserts tc.
REQ-024 In RUN with en=0, or in IDLE, q SHALL hold.
REQ-025 A direction change SHALL take effect on the next counting edge with no skipped or repeated value.
REQ-026 Count latency SHALL be 1 cycle: a qualifying input at edge N appears on q after edge N.
REQ-027 busy SHALL equal (state==RUN) as a registered decode; counting begins on the first edge after busy rises.
REQ-028 err SHALL remain 1 until rst; a later valid load does not clear it.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL set q=0, qb=all-ones, tc=0, busy=0, err=0 and state=IDLE, overriding every other input.
REQ-030 rst asserted mid-RUN, including in the same cycle as a wrap, SHALL suppress tc and return the block to IDLE on that edge.
REQ-031 No output SHALL change asynchronously with rst; only qb follows q combinationally.

Verification (WIDTH=4, MOD=10)
REQ-032 Reset then start=1, en=1, up=1 for 12 cycles -> q steps 0,1,...,9,0,1; tc high only in the cycle q=0 after 9; busy=1 throughout.
REQ-033 load=1, din=3, then RUN with up=0, en=1 -> q 3,2,1,0,9,8; tc pulses once, in the cycle q=9.
REQ-034 load=1, din=12 -> q=9, err=1; then load din=2 -> q=2, err stays 1; then rst -> err=0, q=0.
REQ-035 RUN at q=5 with start=1, stop=1 in the same cycle -> busy=0 next cycle, q holds 5; en toggling in IDLE leaves q unchanged.
REQ-036 RUN, up=1, q=9, with rst=1 on the wrap edge -> q=0, tc=0, busy=0.
REQ-037 RUN with en=1, alternate up every cycle from q=4 -> q 5,4,5,4; qb = ~q on every cycle.

Source files
------------

// File: rtl/jk_mod_counter_if.sv
// jk_mod_counter_if: control and count signals of the JK modulo counter
interface jk_mod_counter_if #(parameter int WIDTH = 4);
  logic             start;
  logic             stop;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             tc;
  logic             busy;
  logic             err;
  modport master (output start, stop, en, up, load, din, input q, qb, tc, busy, err);
  modport slave  (input start, stop, en, up, load, din, output q, qb, tc, busy, err);
endinterface

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: start/stop controlled up/down modulo counter built from per-bit JK flops
module jk_mod_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input logic              clk,
  input logic              rst,
  jk_mod_counter_if.slave  bus
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MODW = (WIDTH + 1)'(MOD);
  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_q;
  logic             r_tc, r_err;
  logic             w_count, w_wrap, w_over;
  logic [WIDTH-1:0] w_cnt, w_ldv, w_t, w_j, w_k;
  assign w_over  = {1'b0, bus.din} >= MODW;
  assign w_ldv   = w_over ? MAXV : bus.din;
  assign w_count = (r_state == RUN) && bus.en && !bus.load && !bus.stop;
  assign w_wrap  = bus.up ? (r_q == MAXV) : (r_q == '0);
  assign w_cnt   = bus.up ? (w_wrap ? '0 : r_q + WIDTH'(1)) : (w_wrap ? MAXV : r_q - WIDTH'(1));
  assign w_t     = r_q ^ w_cnt;
  assign w_j     = rst ? '0 : bus.load ? w_ldv  : w_count ? w_t : '0;
  assign w_k     = rst ? '1 : bus.load ? ~w_ldv : w_count ? w_t : '0;
  // stop dominates start; otherwise start moves IDLE to RUN
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = bus.stop ? IDLE : bus.start ? RUN : r_state;
  end
  // state register
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_state_nx;
  end
  // JK update of every count bit: set, clear, toggle or hold
  always_ff @(posedge clk) begin
    r_q <= (w_j & ~r_q) | (~w_k & r_q);
  end
  // wrap pulse and sticky out-of-range load flag
  always_ff @(posedge clk) begin
    r_tc  <= !rst && w_count && w_wrap;
    r_err <= !rst && (r_err || (bus.load && w_over));
  end
  assign bus.q    = r_q;
  assign bus.qb   = ~r_q;
  assign bus.tc   = r_tc;
  assign bus.busy = (r_state == RUN);
  assign bus.err  = r_err;
endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter: directed scoreboard bench for jk_mod_counter (WIDTH=4, MOD=10)
module tb_jk_mod_counter;
  typedef struct packed {
    logic [3:0] q;
    logic       tc;
    logic       busy;
    logic       err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  jk_mod_counter_if #(.WIDTH(4)) bus ();
  jk_mod_counter #(.WIDTH(4), .MOD(10)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic st, input logic sp, input logic e,
                      input logic u, input logic ld, input logic [3:0] d,
                      input logic [3:0] eq, input logic etc, input logic eb, input logic ee);
    exp_t x;
    @(negedge clk);
    rst = r; bus.start = st; bus.stop = sp; bus.en = e; bus.up = u; bus.load = ld; bus.din = d;
    sb.push_back('{q: eq, tc: etc, busy: eb, err: ee});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, ".q"}, bus.q, x.q);
    chk({tag, ".qb"}, bus.qb, ~x.q);
    chk({tag, ".tc"}, {3'b0, bus.tc}, {3'b0, x.tc});
    chk({tag, ".busy"}, {3'b0, bus.busy}, {3'b0, x.busy});
    chk({tag, ".err"}, {3'b0, bus.err}, {3'b0, x.err});
  endtask
  initial begin
    bus.start = 0; bus.stop = 0; bus.en = 0; bus.up = 0; bus.load = 0; bus.din = 0;
    //          tag      rst st sp en up ld din   q  tc b  e
    step("reset",   1, 0, 0, 0, 0, 0, 4'd0,  4'd0, 0, 0, 0);
    step("start",   0, 1, 0, 1, 1, 0, 4'd0,  4'd0, 0, 1, 0);
    for (int i = 1; i <= 11; i++)
      step("up_run", 0, 1, 0, 1, 1, 0, 4'd0, 4'(i % 10), (i == 10), 1, 0);
    step("stop",    0, 0, 1, 0, 1, 0, 4'd0,  4'd1, 0, 0, 0);
    step("ld3",     0, 0, 0, 0, 0, 1, 4'd3,  4'd3, 0, 0, 0);
    step("run_dn",  0, 1, 0, 0, 0, 0, 4'd0,  4'd3, 0, 1, 0);
    step("dn2",     0, 1, 0, 1, 0, 0, 4'd0,  4'd2, 0, 1, 0);
    step("dn1",     0, 1, 0, 1, 0, 0, 4'd0,  4'd1, 0, 1, 0);
    step("dn0",     0, 1, 0, 1, 0, 0, 4'd0,  4'd0, 0, 1, 0);
    step("dn_wrap", 0, 1, 0, 1, 0, 0, 4'd0,  4'd9, 1, 1, 0);
    step("dn8",     0, 1, 0, 1, 0, 0, 4'd0,  4'd8, 0, 1, 0);
    step("stop2",   0, 0, 1, 1, 0, 0, 4'd0,  4'd8, 0, 0, 0);
    step("ld12",    0, 0, 0, 0, 0, 1, 4'd12, 4'd9, 0, 0, 1);
    step("ld2",     0, 0, 0, 0, 0, 1, 4'd2,  4'd2, 0, 0, 1);
    step("rst_err", 1, 0, 0, 0, 0, 0, 4'd0,  4'd0, 0, 0, 0);
    step("ld4",     0, 0, 0, 0, 0, 1, 4'd4,  4'd4, 0, 0, 0);
    step("run5",    0, 1, 0, 0, 1, 0, 4'd0,  4'd4, 0, 1, 0);
    step("up5",     0, 1, 0, 1, 1, 0, 4'd0,  4'd5, 0, 1, 0);
    step("st_sp",   0, 1, 1, 1, 1, 0, 4'd0,  4'd5, 0, 0, 0);
    step("idle_e1", 0, 0, 0, 1, 1, 0, 4'd0,  4'd5, 0, 0, 0);
    step("idle_e0", 0, 0, 0, 0, 1, 0, 4'd0,  4'd5, 0, 0, 0);
    step("idle_e1b",0, 0, 0, 1, 0, 0, 4'd0,  4'd5, 0, 0, 0);
    step("ld8",     0, 0, 0, 0, 0, 1, 4'd8,  4'd8, 0, 0, 0);
    step("run8",    0, 1, 0, 0, 1, 0, 4'd0,  4'd8, 0, 1, 0);
    step("up9",     0, 1, 0, 1, 1, 0, 4'd0,  4'd9, 0, 1, 0);
    step("rst_wrap",1, 1, 0, 1, 1, 0, 4'd0,  4'd0, 0, 0, 0);
    step("ld4b",    0, 0, 0, 0, 0, 1, 4'd4,  4'd4, 0, 0, 0);
    step("run4",    0, 1, 0, 0, 1, 0, 4'd0,  4'd4, 0, 1, 0);
    step("alt_u",   0, 1, 0, 1, 1, 0, 4'd0,  4'd5, 0, 1, 0);
    step("alt_d",   0, 1, 0, 1, 0, 0, 4'd0,  4'd4, 0, 1, 0);
    step("alt_u2",  0, 1, 0, 1, 1, 0, 4'd0,  4'd5, 0, 1, 0);
    step("alt_d2",  0, 1, 0, 1, 0, 0, 4'd0,  4'd4, 0, 1, 0);
    step("ld9_run", 0, 1, 0, 1, 1, 1, 4'd9,  4'd9, 0, 1, 0);
    step("up_wrap", 0, 1, 0, 1, 1, 0, 4'd0,  4'd0, 1, 1, 0);
    step("ld9b",    0, 1, 0, 1, 1, 1, 4'd9,  4'd9, 0, 1, 0);
    step("ld_at_wr",0, 1, 0, 1, 1, 1, 4'd0,  4'd0, 0, 1, 0);
    step("ld_stop", 0, 0, 1, 1, 1, 1, 4'd7,  4'd7, 0, 0, 0);
    step("ld9",     0, 0, 0, 0, 0, 1, 4'd9,  4'd9, 0, 0, 0);
    step("ld10",    0, 0, 0, 0, 0, 1, 4'd10, 4'd9, 0, 0, 1);
    step("hold_err",0, 0, 0, 0, 0, 0, 4'd0,  4'd9, 0, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
